// File: rtl/mapper_shadow_seq.sv
`default_nettype none
// ============================================================================
// Module      : mapper_shadow_seq
// Description : Saves the user-mode 4510 MAP register set (A, X, Y, Z of
//               map 0) into shadow registers on hypervisor entry and writes
//               it back, Z last, on hypervisor exit, then waits for the
//               mapper's fast-table refresh to complete.
// Revision    : 1.0 - initial release
// ============================================================================
module mapper_shadow_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       save_req,
    input  logic       restore_req,
    input  logic       map_active,
    input  logic       mapper_busy,
    input  logic [7:0] map_reg_data,
    output logic [1:0] rd_sel,
    output logic       rd_sel_valid,
    output logic [1:0] wr_sel,
    output logic       wr_load,
    input  logic       host_we,
    input  logic [1:0] host_sel,
    input  logic [7:0] host_data,
    output logic [7:0] shadow_a,
    output logic [7:0] shadow_x,
    output logic [7:0] shadow_y,
    output logic [7:0] shadow_z,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAVE    = 3'd1,
        S_RESTORE = 3'd2,
        S_SETTLE0 = 3'd3,
        S_SETTLE  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Mapper register select encoding
    localparam logic [1:0] SEL_A = 2'd3;
    localparam logic [1:0] SEL_X = 2'd2;
    localparam logic [1:0] SEL_Y = 2'd1;
    localparam logic [1:0] SEL_Z = 2'd0;

    state_t     state_q, state_d;
    logic [1:0] index_q, index_d;
    logic [7:0] shadow_a_q, shadow_a_d;
    logic [7:0] shadow_x_q, shadow_x_d;
    logic [7:0] shadow_y_q, shadow_y_d;
    logic [7:0] shadow_z_q, shadow_z_d;
    logic [1:0] rd_sel_q, rd_sel_d;
    logic       rd_sel_valid_q, rd_sel_valid_d;
    logic [1:0] wr_sel_q, wr_sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Next state and index; a MAP instruction in flight stalls the restore
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        case (state_q)
            S_IDLE: begin
                if (save_req) begin
                    index_d = 2'd3;
                    state_d = S_SAVE;
                end else if (restore_req) begin
                    index_d = 2'd3;
                    state_d = S_RESTORE;
                end
            end
            S_SAVE: begin
                if (index_q == 2'd0) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q - 2'd1;
                end
            end
            S_RESTORE: begin
                if (!map_active) begin
                    if (index_q == 2'd0) begin
                        state_d = S_SETTLE0;
                    end else begin
                        index_d = index_q - 2'd1;
                    end
                end
            end
            // mapper_busy only rises the cycle after the Z load, so skip one cycle
            S_SETTLE0: state_d = S_SETTLE;
            S_SETTLE: begin
                if (!mapper_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they are registered with it
    always_comb begin
        rd_sel_valid_d = (state_d == S_SAVE);
        rd_sel_d       = (state_d == S_SAVE)    ? index_d : 2'd0;
        wr_sel_d       = (state_d == S_RESTORE) ? index_d : 2'd0;
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
    end

    // Shadow updates: mapper readback while saving, host writes only when idle
    always_comb begin
        shadow_a_d = shadow_a_q;
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        shadow_z_d = shadow_z_q;
        if (state_q == S_SAVE) begin
            case (index_q)
                SEL_A:   shadow_a_d = map_reg_data;
                SEL_X:   shadow_x_d = map_reg_data;
                SEL_Y:   shadow_y_d = map_reg_data;
                default: shadow_z_d = map_reg_data;
            endcase
        end else if ((state_q == S_IDLE) && host_we) begin
            case (host_sel)
                SEL_A:   shadow_a_d = host_data;
                SEL_X:   shadow_x_d = host_data;
                SEL_Y:   shadow_y_d = host_data;
                default: shadow_z_d = host_data;
            endcase
        end
    end

    // State, index, shadows and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            index_q        <= 2'd0;
            shadow_a_q     <= 8'h00;
            shadow_x_q     <= 8'h00;
            shadow_y_q     <= 8'h00;
            shadow_z_q     <= 8'h00;
            rd_sel_q       <= 2'd0;
            rd_sel_valid_q <= 1'b0;
            wr_sel_q       <= 2'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            shadow_a_q     <= shadow_a_d;
            shadow_x_q     <= shadow_x_d;
            shadow_y_q     <= shadow_y_d;
            shadow_z_q     <= shadow_z_d;
            rd_sel_q       <= rd_sel_d;
            rd_sel_valid_q <= rd_sel_valid_d;
            wr_sel_q       <= wr_sel_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // The load strobe is the one output gated directly by map_active
    assign wr_load      = (state_q == S_RESTORE) && !map_active;
    assign rd_sel       = rd_sel_q;
    assign rd_sel_valid = rd_sel_valid_q;
    assign wr_sel       = wr_sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign shadow_a     = shadow_a_q;
    assign shadow_x     = shadow_x_q;
    assign shadow_y     = shadow_y_q;
    assign shadow_z     = shadow_z_q;

endmodule
`default_nettype wire

// File: tb/tb_mapper_shadow_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mapper_shadow_seq
// Description : Self-checking bench for mapper_shadow_seq with a small mapper
//               model and a scoreboard of expected selects, writes and done
//               cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mapper_shadow_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       save_req, restore_req, map_active, mapper_busy;
    logic [7:0] map_reg_data;
    logic [1:0] rd_sel, wr_sel, host_sel;
    logic       rd_sel_valid, wr_load, host_we, busy, done;
    logic [7:0] host_data, shadow_a, shadow_x, shadow_y, shadow_z;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    wr_t        exp_wr[$];
    logic [1:0] exp_rd[$];
    int         exp_done[$];
    logic [7:0] mreg [4];   // mapper registers as read back (set by stimulus)
    logic [7:0] mw   [4];   // mapper registers as written by the DUT
    int         mb_cnt = 0;
    int         nwrites = 0;

    mapper_shadow_seq dut (
        .clk          (clk),
        .reset        (reset),
        .save_req     (save_req),
        .restore_req  (restore_req),
        .map_active   (map_active),
        .mapper_busy  (mapper_busy),
        .map_reg_data (map_reg_data),
        .rd_sel       (rd_sel),
        .rd_sel_valid (rd_sel_valid),
        .wr_sel       (wr_sel),
        .wr_load      (wr_load),
        .host_we      (host_we),
        .host_sel     (host_sel),
        .host_data    (host_data),
        .shadow_a     (shadow_a),
        .shadow_x     (shadow_x),
        .shadow_y     (shadow_y),
        .shadow_z     (shadow_z),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] shadow_of(input logic [1:0] s);
        case (s)
            2'd3:    return shadow_a;
            2'd2:    return shadow_x;
            2'd1:    return shadow_y;
            default: return shadow_z;
        endcase
    endfunction

    // Mapper model: combinational readback, register load, 16-cycle busy after Z
    always_comb map_reg_data = rd_sel_valid ? mreg[rd_sel] : 8'hEE;
    assign mapper_busy = (mb_cnt != 0);

    always @(posedge clk) begin
        if (wr_load) begin
            mw[wr_sel] <= shadow_of(wr_sel);
            if (wr_sel == 2'd0) mb_cnt <= 16;
        end else if (mb_cnt != 0) begin
            mb_cnt <= mb_cnt - 1;
        end
    end

    // Scoreboard side: pop expectations as the DUT produces output
    always @(negedge clk) begin
        if (rd_sel_valid) begin
            if (exp_rd.size() == 0) check_val("rd_sel_extra", 32'(rd_sel_valid), 32'd0);
            else check_val("rd_sel", 32'(rd_sel), 32'(exp_rd.pop_front()));
        end
        if (wr_load) begin
            nwrites++;
            if (map_active) check_val("wr_load_stall", 32'(wr_load), 32'd0);
            if (exp_wr.size() == 0) check_val("wr_extra", 32'(wr_load), 32'd0);
            else begin
                wr_t e;
                e = exp_wr.pop_front();
                check_val("wr_sel", 32'(wr_sel), 32'(e.sel));
                check_val("wr_data", 32'(shadow_of(wr_sel)), 32'(e.data));
            end
        end
        if (done) begin
            if (exp_done.size() == 0) check_val("done_extra", 32'(done), 32'd0);
            else check_val("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic host_write(input logic [1:0] s, input logic [7:0] d);
        host_we = 1'b1; host_sel = s; host_data = d;
        tick();
        host_we = 1'b0;
    endtask

    task automatic push_save_exp(input int n);
        exp_rd.push_back(2'd3); exp_rd.push_back(2'd2);
        exp_rd.push_back(2'd1); exp_rd.push_back(2'd0);
        exp_done.push_back(n + 5);
    endtask

    task automatic push_restore_exp(input int n, input int stall);
        exp_wr.push_back({2'd3, shadow_a}); exp_wr.push_back({2'd2, shadow_x});
        exp_wr.push_back({2'd1, shadow_y}); exp_wr.push_back({2'd0, shadow_z});
        exp_done.push_back(n + 22 + stall);
    endtask

    initial begin
        int bc;
        int w0;
        reset = 1'b1; save_req = 0; restore_req = 0; map_active = 0;
        host_we = 0; host_sel = 0; host_data = 0;
        for (int i = 0; i < 4; i++) begin mreg[i] = 8'h00; mw[i] = 8'h00; end
        wait_cycles(3);

        // Reset state
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_rdv", 32'(rd_sel_valid), 32'd0);
        check_val("rst_wrload", 32'(wr_load), 32'd0);
        check_val("rst_sels", {28'd0, rd_sel, wr_sel}, 32'd0);
        check_val("rst_shadows", {shadow_a, shadow_x, shadow_y, shadow_z}, 32'd0);
        reset = 1'b0;
        tick();

        // Save: busy exactly 5 cycles, done at N+5
        mreg[3] = 8'h12; mreg[2] = 8'h34; mreg[1] = 8'h56; mreg[0] = 8'h78;
        push_save_exp(cyc);
        save_req = 1'b1; tick(); save_req = 1'b0;
        bc = 0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (busy) bc++; end
        tick();
        check_val("save_busy_len", 32'(bc), 32'd5);
        check_val("save_shadows", {shadow_a, shadow_x, shadow_y, shadow_z}, 32'h12345678);

        // Host writes in IDLE
        host_write(2'd2, 8'h5A);
        check_val("host_x", 32'(shadow_x), 32'h5A);
        host_write(2'd3, 8'hC0); host_write(2'd2, 8'h3F);
        host_write(2'd1, 8'h00); host_write(2'd0, 8'h31);
        check_val("host_all", {shadow_a, shadow_x, shadow_y, shadow_z}, 32'hC03F0031);

        // Restore: done exactly 22 cycles after request
        push_restore_exp(cyc, 0);
        w0 = nwrites;
        restore_req = 1'b1; tick(); restore_req = 1'b0;
        wait_cycles(26);
        check_val("restore_nwr", 32'(nwrites - w0), 32'd4);
        check_val("restore_mapper", {mw[3], mw[2], mw[1], mw[0]}, 32'hC03F0031);

        // Stall: map_active for 3 cycles while index=1
        for (int i = 0; i < 4; i++) mw[i] = 8'h00;
        push_restore_exp(cyc, 3);
        w0 = nwrites;
        restore_req = 1'b1; tick(); restore_req = 1'b0;   // now N+1
        wait_cycles(2);                                   // now N+3, index=1
        map_active = 1'b1;
        wait_cycles(3);
        map_active = 1'b0;
        wait_cycles(24);
        check_val("stall_nwr", 32'(nwrites - w0), 32'd4);
        check_val("stall_mapper", {mw[3], mw[2], mw[1], mw[0]}, 32'hC03F0031);

        // Simultaneous requests: save wins; restore and host write during SAVE ignored
        mreg[3] = 8'h9A; mreg[2] = 8'hBC; mreg[1] = 8'hDE; mreg[0] = 8'hF0;
        push_save_exp(cyc);
        w0 = nwrites;
        save_req = 1'b1; restore_req = 1'b1; tick();
        save_req = 1'b0; restore_req = 1'b0;              // now N+1
        tick();                                           // N+2
        restore_req = 1'b1; tick(); restore_req = 1'b0;   // N+3
        host_write(2'd2, 8'hAA);                          // N+3 inside SAVE
        wait_cycles(6);
        check_val("simul_busy", 32'(busy), 32'd0);
        check_val("simul_nwr", 32'(nwrites - w0), 32'd0);
        check_val("simul_shadows", {shadow_a, shadow_x, shadow_y, shadow_z}, 32'h9ABCDEF0);

        // Asynchronous reset at N+3 of a restore
        push_restore_exp(cyc, 0);
        restore_req = 1'b1; tick(); restore_req = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
        #1;
        check_val("arst_outs", {27'd0, busy, done, rd_sel_valid, wr_load, 1'b0}, 32'd0);
        check_val("arst_sels", {28'd0, rd_sel, wr_sel}, 32'd0);
        check_val("arst_shadows", {shadow_a, shadow_x, shadow_y, shadow_z}, 32'd0);
        exp_wr.delete();
        exp_done.delete();
        tick();
        reset = 1'b0;
        wait_cycles(20);

        // Save accepted normally after the abort
        mreg[3] = 8'h01; mreg[2] = 8'h23; mreg[1] = 8'h45; mreg[0] = 8'h67;
        push_save_exp(cyc);
        save_req = 1'b1; tick(); save_req = 1'b0;
        wait_cycles(8);
        check_val("post_rst_save", {shadow_a, shadow_x, shadow_y, shadow_z}, 32'h01234567);
        check_val("post_rst_busy", 32'(busy), 32'd0);

        // Every expectation must have been consumed
        check_val("left_rd", 32'(exp_rd.size()), 32'd0);
        check_val("left_wr", 32'(exp_wr.size()), 32'd0);
        check_val("left_done", 32'(exp_done.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mapper_shadow_seq.md
# mapper_shadow_seq

Sequencer that saves and restores the user-mode 4510 MAP register set (A, X, Y, Z bytes of map 0) through the mapper's hypervisor register port, the opposite end of the mapper's hypervisor interface. On hypervisor entry it reads the four bytes out of the mapper into shadow registers. On hypervisor exit it writes them back, Z last, and waits for the fast-mapper table refresh to finish. It sits in the hypervisor controller between the trap logic and the mapper.

## Interface
Parameters:
- none (register order and widths fixed by the mapper: sel 3=A, 2=X, 1=Y, 0=Z)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- save_req  in  1  single-cycle pulse: capture mapper regs into shadows
- restore_req  in  1  single-cycle pulse: write shadows back to mapper
- map_active  in  1  mapper FSM `map` flag; high while a MAP instruction is executing
- mapper_busy  in  1  mapper fast-table refresh in progress
- map_reg_data  in  8  mapper register readback (combinational from select)
- rd_sel  out  2  register select driven to mapper readback mux
- rd_sel_valid  out  1  high while rd_sel must override the core address bits
- wr_sel  out  2  to mapper `map_reg_write_sel`
- wr_load  out  1  to mapper `hypervisor_load_user_reg`
- host_we  in  1  hypervisor write to one shadow byte
- host_sel  in  2  shadow select for host_we (same encoding)
- host_data  in  8  shadow write data
- shadow_a, shadow_x, shadow_y, shadow_z  out  8 each  shadow contents
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence completion

## Operation
- States: IDLE, SAVE, RESTORE, SETTLE0, SETTLE, DONE. A 2-bit index counts 3 down to 0.
- IDLE:
  - save_req: load index=3, go to SAVE.
  - else restore_req: load index=3, go to RESTORE.
  - Both requests in the same cycle: save wins; the restore is dropped.
- SAVE:
  - rd_sel_valid=1, rd_sel=index.
  - Each cycle, map_reg_data is written into the shadow selected by index.
  - index=0: go to DONE, else decrement.
- RESTORE:
  - wr_sel=index. wr_load=1 only when map_active=0.
  - map_active=1: wr_load=0 and index holds (stall).
  - After a write with index=0 (Z), go to SETTLE0, else decrement.
- SETTLE0: one cycle, mapper_busy ignored because the mapper asserts it one cycle after load_z. Go to SETTLE.
- SETTLE: stay while mapper_busy=1. Go to DONE when mapper_busy=0.
- DONE: done=1 for one cycle, go to IDLE.
- busy=1 in every state except IDLE.
- save_req/restore_req outside IDLE: ignored, not queued.
- host_we: honoured only in IDLE, else ignored. Writes host_data into the shadow selected by host_sel (3=A, 2=X, 1=Y, 0=Z).
- Shadow outputs are registered and change only on SAVE captures, host writes, or reset.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, index 0.
  - All shadows 8'h00.
  - rd_sel=0, rd_sel_valid=0, wr_sel=0, wr_load=0, busy=0, done=0.
- All outputs are registered or decoded from state/index only; no combinational input-to-output path except the wr_load gating by map_active.
- Save latency, with req at cycle N:
  - SAVE on cycles N+1..N+4 (A, X, Y, Z captured at the end of each).
  - done at N+5; IDLE at N+6.
- Restore latency, no stalls, mapper_busy held 16 cycles:
  - wr_load on N+1..N+4; Z written on N+4.
  - SETTLE0 at N+5; mapper_busy high N+5..N+20.
  - SETTLE exits on the first cycle mapper_busy=0 (N+21); done at N+22.
- Each cycle of map_active=1 during RESTORE adds exactly one cycle.
- Reset mid-sequence aborts to IDLE:
  - Already-captured shadow bytes are lost (cleared).
  - Partially-written mapper state is not repaired.

## Test plan
- Save: mapper regs A=8'h12, X=8'h34, Y=8'h56, Z=8'h78; pulse save_req -> rd_sel 3,2,1,0 on 4 consecutive cycles; shadows A..Z = 12/34/56/78; done 5 cycles after req; busy high for exactly 5 cycles.
- Restore: host writes A=8'hC0, X=8'h3F, Y=8'h00, Z=8'h31; pulse restore_req; mapper model holds busy 16 cycles after Z -> wr_sel 3,2,1,0 with wr_load each cycle; done exactly 22 cycles after req.
- Stall: map_active=1 for 3 cycles while index=1 in RESTORE -> wr_load low those 3 cycles; Y written once, never twice; done delayed by 3 cycles.
- Simultaneous save_req+restore_req in IDLE -> SAVE runs, no wr_load ever asserted; restore_req pulsed during SAVE -> ignored, busy drops after the save's done.
- host_we during SAVE with host_data=8'hAA -> shadows unchanged by the host write; host_we in IDLE with sel=2, data=8'h5A -> shadow_x=8'h5A next cycle.
- Assert reset at cycle N+3 of a restore -> all outputs 0 immediately (asynchronous), shadows 8'h00, later save_req accepted normally.
